mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_if.sv | 41 ++++
 rtl/mem_bus_arbiter.sv | 110 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - CPU, DMA and shared-bus signal bundle for mem_bus_arbiter
interface mem_bus_arbiter_if;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req;
    logic        dma_wr;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [31:0] dma_rdata;
    logic        dma_gnt;
    logic        bus_rd;
    logic        bus_wr;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        sel_mem;
    logic        sel_periph;
    logic        sel_uart;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  dma_req, dma_wr, dma_addr, dma_wdata,
        input  bus_rdata,
        output cpu_rdata, cpu_stall, dma_rdata, dma_gnt,
        output bus_rd, bus_wr, bus_addr, bus_wdata,
        output sel_mem, sel_periph, sel_uart
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output dma_req, dma_wr, dma_addr, dma_wdata,
        output bus_rdata,
        input  cpu_rdata, cpu_stall, dma_rdata, dma_gnt,
        input  bus_rd, bus_wr, bus_addr, bus_wdata,
        input  sel_mem, sel_periph, sel_uart
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - CPU/DMA shared-bus arbiter with bounded DMA bursts and starvation override
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int BURST_MAX    = 4
) (
    input  logic             sys_clk,
    input  logic             reset,
    mem_bus_arbiter_if.slave bus
);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [BW-1:0] L_BURST_MAX = BW'(BURST_MAX);
    localparam logic [SW-1:0] L_STARVE    = SW'(STARVE_LIMIT);

    typedef enum logic {IDLE, DMA_BURST} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [BW-1:0] r_beat_cnt;
    logic [BW-1:0] w_beat_next;
    logic [BW-1:0] w_beat_inc;
    logic [SW-1:0] r_starve_cnt;
    logic [SW-1:0] w_starve_next;
    owner_t        w_owner;
    logic          w_cpu_req;
    logic          w_uart_hit;

    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_beat_cnt   <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_beat_cnt   <= w_beat_next;
            r_starve_cnt <= w_starve_next;
        end
    end

    assign bus.cpu_rdata = bus.bus_rdata;
    assign bus.dma_rdata = bus.bus_rdata;

    always_comb begin
        w_cpu_req     = bus.cpu_rd | bus.cpu_wr;
        w_owner       = OWN_NONE;
        w_state_next  = IDLE;
        w_beat_next   = '0;
        w_starve_next = '0;
        w_beat_inc    = (r_state == DMA_BURST) ? r_beat_cnt + 1'b1 : BW'(1);
        bus.bus_rd    = 1'b0;
        bus.bus_wr    = 1'b0;
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;
        bus.dma_gnt   = 1'b0;
        bus.cpu_stall = 1'b0;
        bus.sel_mem   = 1'b0;
        bus.sel_periph = 1'b0;
        bus.sel_uart  = 1'b0;

        // An unfinished burst or a starved DMA outranks the CPU.
        if (!reset) begin
            w_owner = OWN_NONE;
        end else if (bus.dma_req && ((r_state == DMA_BURST && r_beat_cnt < L_BURST_MAX) ||
                                     r_starve_cnt == L_STARVE)) begin
            w_owner = OWN_DMA;
        end else if (w_cpu_req) begin
            w_owner = OWN_CPU;
        end else if (bus.dma_req) begin
            w_owner = OWN_DMA;
        end

        if (w_owner == OWN_DMA) begin
            if (w_beat_inc < L_BURST_MAX) begin
                w_state_next = DMA_BURST;
                w_beat_next  = w_beat_inc;
            end
        end else if (bus.dma_req) begin
            w_starve_next = (r_starve_cnt == L_STARVE) ? r_starve_cnt : r_starve_cnt + 1'b1;
        end

        case (w_owner)
            OWN_CPU: begin
                bus.bus_rd    = bus.cpu_rd;
                bus.bus_wr    = bus.cpu_wr;
                bus.bus_addr  = bus.cpu_addr;
                bus.bus_wdata = bus.cpu_wdata;
            end
            OWN_DMA: begin
                bus.bus_rd    = ~bus.dma_wr;
                bus.bus_wr    = bus.dma_wr;
                bus.bus_addr  = bus.dma_addr;
                bus.bus_wdata = bus.dma_wdata;
                bus.dma_gnt   = 1'b1;
            end
            default: ;
        endcase

        bus.cpu_stall = reset & w_cpu_req & (w_owner != OWN_CPU);

        w_uart_hit = bus.bus_addr[30] &&
                     (bus.bus_addr[5:0] == 6'h18 || bus.bus_addr[5:0] == 6'h1C ||
                      bus.bus_addr[5:0] == 6'h20);
        if (w_owner != OWN_NONE) begin
            bus.sel_mem    = ~bus.bus_addr[30];
            bus.sel_uart   = w_uart_hit;
            bus.sel_periph = bus.bus_addr[30] & ~w_uart_hit;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter with directed and random traffic
module tb_mem_bus_arbiter;
    localparam int STARVE_LIMIT = 8;
    localparam int BURST_MAX    = 4;

    typedef struct packed {
        logic [1:0]  own;
        logic        stall;
        logic        gnt;
        logic        rd;
        logic        wr;
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic sys_clk;
    logic reset;
    mem_bus_arbiter_if bif();

    mem_bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .BURST_MAX(BURST_MAX)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bif)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t sb[$];

    logic        d_rstn, d_cpu_rd, d_cpu_wr, d_dma_req, d_dma_wr;
    logic [31:0] d_cpu_addr, d_cpu_wdata, d_dma_addr, d_dma_wdata, d_rdata;

    bit m_in_burst;
    int m_beats;
    int m_wait;
    bit p_cpu;
    bit p_dma;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    function automatic logic [2:0] region(input logic [31:0] a);
        int low;
        low = int'(a[5:0]);
        if (!a[30]) return 3'b100;
        if (low == 24 || low == 28 || low == 32) return 3'b001;
        return 3'b010;
    endfunction

    task automatic model_step();
        exp_t e;
        bit   cq;
        bit   dma_first;
        e  = '0;
        cq = d_cpu_rd | d_cpu_wr;
        dma_first = d_dma_req && ((m_in_burst && m_beats < BURST_MAX) || m_wait == STARVE_LIMIT);
        if (!d_rstn)         e.own = 2'd0;
        else if (dma_first)  e.own = 2'd2;
        else if (cq)         e.own = 2'd1;
        else if (d_dma_req)  e.own = 2'd2;
        if (e.own == 2'd1) begin
            e.rd = d_cpu_rd;  e.wr = d_cpu_wr;  e.addr = d_cpu_addr;  e.wdata = d_cpu_wdata;
        end else if (e.own == 2'd2) begin
            e.rd = !d_dma_wr; e.wr = d_dma_wr;  e.addr = d_dma_addr;  e.wdata = d_dma_wdata;
            e.gnt = 1'b1;
        end
        e.stall = d_rstn && cq && e.own != 2'd1;
        if (e.own != 2'd0) e.sel = region(e.addr);
        e.rdata = d_rdata;
        sb.push_back(e);
        p_cpu = cq && e.stall;
        p_dma = d_dma_req && !e.gnt;
        if (!d_rstn) begin
            m_in_burst = 0; m_beats = 0; m_wait = 0;
        end else if (e.own == 2'd2) begin
            m_beats = m_in_burst ? m_beats + 1 : 1;
            m_wait  = 0;
            if (m_beats >= BURST_MAX) begin m_in_burst = 0; m_beats = 0; end
            else m_in_burst = 1;
        end else begin
            m_in_burst = 0; m_beats = 0;
            m_wait = d_dma_req ? ((m_wait < STARVE_LIMIT) ? m_wait + 1 : STARVE_LIMIT) : 0;
        end
    endtask

    task automatic drive_cycle();
        @(posedge sys_clk);
        #1;
        cyc++;
        reset         = d_rstn;
        bif.cpu_rd    = d_cpu_rd;
        bif.cpu_wr    = d_cpu_wr;
        bif.cpu_addr  = d_cpu_addr;
        bif.cpu_wdata = d_cpu_wdata;
        bif.dma_req   = d_dma_req;
        bif.dma_wr    = d_dma_wr;
        bif.dma_addr  = d_dma_addr;
        bif.dma_wdata = d_dma_wdata;
        bif.bus_rdata = d_rdata;
        model_step();
    endtask

    task automatic idle_in();
        d_rstn = 1; d_cpu_rd = 0; d_cpu_wr = 0; d_dma_req = 0; d_dma_wr = 0;
        d_cpu_addr = '0; d_cpu_wdata = '0; d_dma_addr = '0; d_dma_wdata = '0;
    endtask

    task automatic run_idle(input int n);
        idle_in();
        for (int i = 0; i < n; i++) drive_cycle();
    endtask

    task automatic cyc_chk(input string name, input logic want_gnt, input logic want_stall);
        drive_cycle();
        #2;
        chk({name, "_gnt"}, bif.dma_gnt, want_gnt);
        chk({name, "_stall"}, bif.cpu_stall, want_stall);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int          k;
        a     = $urandom;
        a[30] = 1'($urandom_range(0, 1));
        k     = $urandom_range(0, 5);
        if (k == 0) a[5:0] = 6'h18;
        else if (k == 1) a[5:0] = 6'h1C;
        else if (k == 2) a[5:0] = 6'h20;
        return a;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("sb_ctrl@%0d", cyc),
                    {25'd0, bif.cpu_stall, bif.dma_gnt, bif.bus_rd, bif.bus_wr,
                     bif.sel_mem, bif.sel_periph, bif.sel_uart},
                    {25'd0, e.stall, e.gnt, e.rd, e.wr, e.sel});
                chk($sformatf("sb_addr@%0d", cyc), bif.bus_addr, e.addr);
                chk($sformatf("sb_wdata@%0d", cyc), bif.bus_wdata, e.wdata);
                if (e.own == 2'd1) chk($sformatf("sb_cpu_rdata@%0d", cyc), bif.cpu_rdata, e.rdata);
                if (e.own == 2'd2) chk($sformatf("sb_dma_rdata@%0d", cyc), bif.dma_rdata, e.rdata);
            end
        end
    end

    initial begin : stim
        logic [13:0] pat;
        m_in_burst = 0; m_beats = 0; m_wait = 0;
        reset = 1'b0;
        bif.cpu_rd = 0; bif.cpu_wr = 0; bif.cpu_addr = '0; bif.cpu_wdata = '0;
        bif.dma_req = 0; bif.dma_wr = 0; bif.dma_addr = '0; bif.dma_wdata = '0;
        bif.bus_rdata = '0;
        d_rdata = 32'h0;

        // requests present while in reset must be ignored
        idle_in();
        d_rstn = 0; d_cpu_wr = 1; d_dma_req = 1; d_dma_wr = 1;
        d_cpu_addr = 32'h0000_0040; d_dma_addr = 32'h4000_0018;
        drive_cycle();
        drive_cycle();
        #2;
        chk("rst_gnt", bif.dma_gnt, 1'b0);
        chk("rst_stall", bif.cpu_stall, 1'b0);
        chk("rst_strobes", {bif.bus_rd, bif.bus_wr}, 2'b00);
        chk("rst_sel", {bif.sel_mem, bif.sel_periph, bif.sel_uart}, 3'b000);
        run_idle(2);

        // CPU-only read completes in the same cycle
        d_cpu_rd = 1; d_cpu_addr = 32'h0000_0010; d_rdata = 32'hDEAD_BEEF;
        drive_cycle();
        #2;
        chk("cpu_rd_stall", bif.cpu_stall, 1'b0);
        chk("cpu_rd_busrd", bif.bus_rd, 1'b1);
        chk("cpu_rd_sel", {bif.sel_mem, bif.sel_periph, bif.sel_uart}, 3'b100);
        chk("cpu_rd_rdata", bif.cpu_rdata, 32'hDEAD_BEEF);
        run_idle(2);

        // six DMA writes: burst of 4, then a fresh burst from IDLE
        d_dma_req = 1; d_dma_wr = 1;
        for (int i = 0; i < 6; i++) begin
            d_dma_addr = 32'h100 + 4 * i; d_dma_wdata = $urandom;
            cyc_chk($sformatf("burst6_%0d", i), 1'b1, 1'b0);
        end
        // second burst is on beat 2, so two more DMA beats precede the CPU
        d_cpu_wr = 1; d_cpu_addr = 32'h200; d_cpu_wdata = 32'h1234_5678;
        cyc_chk("burst_tail0", 1'b1, 1'b1);
        cyc_chk("burst_tail1", 1'b1, 1'b1);
        cyc_chk("burst_cpu", 1'b0, 1'b0);
        run_idle(2);

        // contention: 8 CPU cycles, 4 starved-DMA beats, CPU again
        pat = 14'b00_1111_00000000;
        d_cpu_wr = 1; d_cpu_addr = 32'h0000_0300; d_cpu_wdata = 32'hA5A5_0000;
        d_dma_req = 1; d_dma_wr = 0; d_dma_addr = 32'h4000_0004;
        for (int i = 0; i < 14; i++) cyc_chk($sformatf("contend_%0d", i), pat[i], pat[i]);
        run_idle(2);

        // region decode
        d_cpu_rd = 1; d_cpu_addr = 32'h4000_001C;
        drive_cycle(); #2;
        chk("dec_uart", {bif.sel_mem, bif.sel_periph, bif.sel_uart}, 3'b001);
        d_cpu_addr = 32'h4000_000C;
        drive_cycle(); #2;
        chk("dec_periph", {bif.sel_mem, bif.sel_periph, bif.sel_uart}, 3'b010);
        d_cpu_addr = 32'h0000_0100;
        drive_cycle(); #2;
        chk("dec_mem", {bif.sel_mem, bif.sel_periph, bif.sel_uart}, 3'b100);
        run_idle(1);

        // reset on beat 2 aborts the burst; after release the CPU wins
        d_dma_req = 1; d_dma_wr = 1; d_dma_addr = 32'h0000_0500;
        cyc_chk("rstb_beat1", 1'b1, 1'b0);
        d_rstn = 0;
        cyc_chk("rstb_beat2", 1'b0, 1'b0);
        d_rstn = 1; d_cpu_wr = 1; d_cpu_addr = 32'h0000_0600;
        cyc_chk("rstb_release", 1'b0, 1'b0);
        chk("rstb_buswr", bif.bus_wr, 1'b1);
        run_idle(2);

        // random traffic honouring hold-until-granted
        for (int n = 0; n < 3000; n++) begin
            if (!p_cpu) begin
                int r;
                r = $urandom_range(0, 3);
                d_cpu_rd = (r == 1); d_cpu_wr = (r == 2);
                d_cpu_addr = rand_addr(); d_cpu_wdata = $urandom;
            end
            if (!p_dma) begin
                d_dma_req = ($urandom_range(0, 9) < 6);
                d_dma_wr = 1'($urandom_range(0, 1));
                d_dma_addr = rand_addr(); d_dma_wdata = $urandom;
            end
            d_rdata = $urandom;
            d_rstn = ($urandom_range(0, 99) != 0);
            drive_cycle();
        end
        run_idle(1);
        @(negedge sys_clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
